vga_sync_generator: RTL and testbench
=====================================

# vga_sync_generator

Downstream consumer of the horizontal and vertical VGA counters. It converts the free-running `horizontal_count` (0–799) and `vertical_count` (0–524) into the following registered outputs for 640x480@60 Hz:
- active-low `hsync`/`vsync`;
- `video_on` and in-frame pixel coordinates;
- single-cycle frame/vblank strobes for the Pong game logic;
- a frame counter.

It also detects out-of-range counter values and latches a sticky error.

## Interface
Parameters:
- `H_VISIBLE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, hsync pulse width (clocks)
- `H_BACK`, 48, horizontal back porch (clocks)
- `V_VISIBLE`, 480, visible lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BACK`, 33, vertical back porch (lines)

Ports:
- `clk_div`  input  1  pixel clock (25 MHz), single clock domain
- `rst_n`  input  1  asynchronous, active-low reset
- `horizontal_count`  input  16  current horizontal position from the horizontal counter
- `vertical_count`  input  16  current vertical position from the vertical counter
- `hsync`  output  1  horizontal sync, active low
- `vsync`  output  1  vertical sync, active low
- `video_on`  output  1  high while the sampled position is in the visible area
- `pixel_x`  output  10  visible column, 0..639; 0 when `video_on`=0
- `pixel_y`  output  10  visible line, 0..479; 0 when `video_on`=0
- `frame_start`  output  1  one-clock strobe at position (0,0)
- `vblank_start`  output  1  one-clock strobe at position (0, `V_VISIBLE`)
- `frame_count`  output  16  number of frames started since reset
- `timing_error`  output  1  sticky flag, set by an out-of-range count

## Operation
- Derived constants:
  - H_TOTAL = sum of the H parameters = 800.
  - V_TOTAL = sum of the V parameters = 525.
  - hsync region: [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] = [656, 751].
  - vsync region: [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] = [490, 491].
- All comparisons are unsigned on the full 16-bit inputs.
- Each `clk_div` rising edge samples both counts and updates every output register from that sample.
- `hsync` = 0 iff `horizontal_count` is in the hsync region; otherwise 1.
- `vsync` = 0 iff `vertical_count` is in the vsync region; otherwise 1. This depends on the line only, not on the horizontal position.
- `video_on` = 1 iff `horizontal_count` < H_VISIBLE and `vertical_count` < V_VISIBLE.
- `pixel_x`/`pixel_y` take the low 10 bits of the counts when `video_on` is 1; otherwise both are 0.
- `frame_start` = 1 for exactly one clock when the sample is (h=0, v=0).
- `vblank_start` = 1 for exactly one clock when the sample is (h=0, v=V_VISIBLE).
- `frame_count` increments on the same edge that asserts `frame_start`, so it already holds the new value during the strobe cycle. It wraps from 65535 to 0.
- Error behaviour:
  - `timing_error` is set when a sample has h ≥ H_TOTAL or v ≥ V_TOTAL.
  - Once set, it clears only on reset.
  - While the flag is set, and on the edge that sets it: `hsync`=1, `vsync`=1, `video_on`=0, `pixel_x`=`pixel_y`=0, both strobes are 0, and `frame_count` holds its value.

## Timing
- Latency: every output reflects the counts sampled at the previous `clk_div` edge (1 clock). No combinational path from input to output.
- Reset: applying `rst_n`=0 immediately forces:
  - `hsync`=1, `vsync`=1;
  - `video_on`=0;
  - `pixel_x`=0, `pixel_y`=0;
  - `frame_start`=0, `vblank_start`=0;
  - `frame_count`=0;
  - `timing_error`=0.
- Release of reset is synchronous to `clk_div`. The first update happens at the first edge with `rst_n`=1.
- Reset mid-frame: outputs return to reset values at once. After release, outputs track the incoming counts with no resynchronisation wait; there is no need to wait for (0,0).
- Strobes are never asserted on two consecutive clocks. If a count stalls at (0,0) for multiple clocks, `frame_start` still pulses once: it requires the previous sample to differ from (0,0). The same rule applies to `vblank_start` at (0,480).
- Horizontal wrap 799→0 while the vertical count advances is handled purely by the sampled values; there is no internal state beyond the output registers, the previous-sample flags and `frame_count`.

## Test plan
- Reset, then drive a full frame (h 0..799, v 0..524, h stepping every clock) → `hsync` low for exactly 96 clocks per line, starting 1 clock after h=656; `vsync` low for lines 490–491; `video_on` high for 640×480 clocks.
- Sample (h=639, v=479) then (640, 479) → `pixel_x`=639, `pixel_y`=479, `video_on`=1, then `video_on`=0, `pixel_x`=0, `pixel_y`=0.
- Run 3 full frames → `frame_start` pulses 3 times, each 1 clock after (0,0); `frame_count` = 1, 2, 3; `vblank_start` pulses 1 clock after each (0,480).
- Drive h=800, then legal counts → `timing_error`=1 and stays 1; `hsync`=`vsync`=1; `video_on`=0; `frame_count` frozen; only reset clears the flag.
- Hold the counts at (0,0) for 5 clocks → a single `frame_start` pulse; `frame_count` increments by 1.
- Assert `rst_n` low at (h=700, v=490) → all outputs go to reset values immediately; after release, `hsync`/`vsync` track the counts on the next clock.

Source files
------------

// File: rtl/vga_sync_generator_if.sv
// rtl/vga_sync_generator_if.sv - counter inputs and sync/timing outputs of the VGA sync generator
interface vga_sync_generator_if;
   logic [15:0] horizontal_count;
   logic [15:0] vertical_count;
   logic        hsync;
   logic        vsync;
   logic        video_on;
   logic [9:0]  pixel_x;
   logic [9:0]  pixel_y;
   logic        frame_start;
   logic        vblank_start;
   logic [15:0] frame_count;
   logic        timing_error;

   modport master (
      output horizontal_count, vertical_count,
      input  hsync, vsync, video_on, pixel_x, pixel_y,
      input  frame_start, vblank_start, frame_count, timing_error
   );

   modport slave (
      input  horizontal_count, vertical_count,
      output hsync, vsync, video_on, pixel_x, pixel_y,
      output frame_start, vblank_start, frame_count, timing_error
   );
endinterface

// File: rtl/vga_sync_generator.sv
// rtl/vga_sync_generator.sv - registered 640x480 sync, pixel coordinates, strobes and sticky range error
module vga_sync_generator #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic                 clk_div,
   input  logic                 rst_n,
   vga_sync_generator_if.slave  bus
);
   localparam logic [15:0] H_TOTAL  = 16'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
   localparam logic [15:0] V_TOTAL  = 16'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
   localparam logic [15:0] H_VIS    = 16'(H_VISIBLE);
   localparam logic [15:0] V_VIS    = 16'(V_VISIBLE);
   localparam logic [15:0] HS_FIRST = 16'(H_VISIBLE + H_FRONT);
   localparam logic [15:0] HS_LAST  = 16'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [15:0] VS_FIRST = 16'(V_VISIBLE + V_FRONT);
   localparam logic [15:0] VS_LAST  = 16'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic [15:0] h_cnt, v_cnt;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic        video_on_q, video_on_d;
   logic [9:0]  pixel_x_q, pixel_x_d;
   logic [9:0]  pixel_y_q, pixel_y_d;
   logic        frame_start_q, frame_start_d;
   logic        vblank_start_q, vblank_start_d;
   logic [15:0] frame_count_q, frame_count_d;
   logic        error_q, error_d;
   logic        at_origin_q, at_origin_d;
   logic        at_vblank_q, at_vblank_d;

   assign h_cnt = bus.horizontal_count;
   assign v_cnt = bus.vertical_count;

   always_comb begin
      error_d        = error_q | (h_cnt >= H_TOTAL) | (v_cnt >= V_TOTAL);
      at_origin_d    = (h_cnt == 16'd0) && (v_cnt == 16'd0);
      at_vblank_d    = (h_cnt == 16'd0) && (v_cnt == V_VIS);
      hsync_d        = 1'b1;
      vsync_d        = 1'b1;
      video_on_d     = 1'b0;
      pixel_x_d      = '0;
      pixel_y_d      = '0;
      frame_start_d  = 1'b0;
      vblank_start_d = 1'b0;
      frame_count_d  = frame_count_q;
      // An error (including the sample that raises it) parks every output idle.
      if (!error_d) begin
         hsync_d        = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
         vsync_d        = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
         video_on_d     = (h_cnt < H_VIS) && (v_cnt < V_VIS);
         pixel_x_d      = video_on_d ? h_cnt[9:0] : 10'd0;
         pixel_y_d      = video_on_d ? v_cnt[9:0] : 10'd0;
         frame_start_d  = at_origin_d && !at_origin_q;
         vblank_start_d = at_vblank_d && !at_vblank_q;
         if (frame_start_d) begin
            frame_count_d = frame_count_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk_div or negedge rst_n) begin
      if (!rst_n) begin
         hsync_q        <= 1'b1;
         vsync_q        <= 1'b1;
         video_on_q     <= 1'b0;
         pixel_x_q      <= '0;
         pixel_y_q      <= '0;
         frame_start_q  <= 1'b0;
         vblank_start_q <= 1'b0;
         frame_count_q  <= '0;
         error_q        <= 1'b0;
         at_origin_q    <= 1'b0;
         at_vblank_q    <= 1'b0;
      end else begin
         hsync_q        <= hsync_d;
         vsync_q        <= vsync_d;
         video_on_q     <= video_on_d;
         pixel_x_q      <= pixel_x_d;
         pixel_y_q      <= pixel_y_d;
         frame_start_q  <= frame_start_d;
         vblank_start_q <= vblank_start_d;
         frame_count_q  <= frame_count_d;
         error_q        <= error_d;
         at_origin_q    <= at_origin_d;
         at_vblank_q    <= at_vblank_d;
      end
   end

   assign bus.hsync        = hsync_q;
   assign bus.vsync        = vsync_q;
   assign bus.video_on     = video_on_q;
   assign bus.pixel_x      = pixel_x_q;
   assign bus.pixel_y      = pixel_y_q;
   assign bus.frame_start  = frame_start_q;
   assign bus.vblank_start = vblank_start_q;
   assign bus.frame_count  = frame_count_q;
   assign bus.timing_error = error_q;
endmodule

// File: tb/tb_vga_sync_generator.sv
// tb/tb_vga_sync_generator.sv - randomized and directed checks of vga_sync_generator against a reference model
module tb_vga_sync_generator;
   localparam int H_TOT = 640 + 16 + 96 + 48;
   localparam int V_TOT = 480 + 10 + 2 + 33;

   logic clk_div = 1'b0;
   logic rst_n   = 1'b0;
   vga_sync_generator_if bus ();

   vga_sync_generator dut (
      .clk_div (clk_div),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   always #5 clk_div = ~clk_div;

   int n_checks = 0;
   int n_fail   = 0;

   // reference state: sticky error, frame count, and the previous sample
   bit m_err;
   int m_fc;
   bit m_have_prev;
   int m_prev_h, m_prev_v;
   int e_hs, e_vs, e_von, e_px, e_py, e_fs, e_vb;

   // observed tallies for per-line / per-run totals
   int t_hs_low, t_vs_low, t_von, t_fs, t_vb;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_err = 0; m_fc = 0; m_have_prev = 0; m_prev_h = 0; m_prev_v = 0;
      e_hs = 1; e_vs = 1; e_von = 0; e_px = 0; e_py = 0; e_fs = 0; e_vb = 0;
   endtask

   task automatic model_sample(input int h, input int v);
      bit prev_origin, prev_vblank;
      prev_origin = m_have_prev && m_prev_h == 0 && m_prev_v == 0;
      prev_vblank = m_have_prev && m_prev_h == 0 && m_prev_v == 480;
      if (h >= H_TOT || v >= V_TOT) m_err = 1;
      if (m_err) begin
         e_hs = 1; e_vs = 1; e_von = 0; e_px = 0; e_py = 0; e_fs = 0; e_vb = 0;
      end else begin
         e_hs  = (h >= 656 && h <= 751) ? 0 : 1;
         e_vs  = (v >= 490 && v <= 491) ? 0 : 1;
         e_von = (h < 640 && v < 480) ? 1 : 0;
         e_px  = e_von ? h : 0;
         e_py  = e_von ? v : 0;
         e_fs  = (h == 0 && v == 0 && !prev_origin) ? 1 : 0;
         e_vb  = (h == 0 && v == 480 && !prev_vblank) ? 1 : 0;
         if (e_fs == 1) m_fc = (m_fc + 1) % 65536;
      end
      m_have_prev = 1; m_prev_h = h; m_prev_v = v;
   endtask

   task automatic compare_all();
      chk("hsync",        32'(bus.hsync),        32'(e_hs));
      chk("vsync",        32'(bus.vsync),        32'(e_vs));
      chk("video_on",     32'(bus.video_on),     32'(e_von));
      chk("pixel_x",      32'(bus.pixel_x),      32'(e_px));
      chk("pixel_y",      32'(bus.pixel_y),      32'(e_py));
      chk("frame_start",  32'(bus.frame_start),  32'(e_fs));
      chk("vblank_start", 32'(bus.vblank_start), 32'(e_vb));
      chk("frame_count",  32'(bus.frame_count),  32'(m_fc));
      chk("timing_error", 32'(bus.timing_error), 32'(m_err));
   endtask

   // Starts and ends on a falling edge; counts are sampled by the rising edge in between.
   task automatic step(input int h, input int v);
      bus.horizontal_count = 16'(h);
      bus.vertical_count   = 16'(v);
      @(posedge clk_div);
      model_sample(h, v);
      #1;
      compare_all();
      t_hs_low += (bus.hsync == 1'b0) ? 1 : 0;
      t_vs_low += (bus.vsync == 1'b0) ? 1 : 0;
      t_von    += bus.video_on ? 1 : 0;
      t_fs     += bus.frame_start ? 1 : 0;
      t_vb     += bus.vblank_start ? 1 : 0;
      @(negedge clk_div);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(posedge clk_div);
      #1;
      compare_all();
      @(negedge clk_div);
      rst_n = 1'b1;
   endtask

   task automatic clear_tallies();
      t_hs_low = 0; t_vs_low = 0; t_von = 0; t_fs = 0; t_vb = 0;
   endtask

   int lines [7] = '{0, 240, 479, 480, 490, 491, 524};
   int fc_before;

   initial begin
      bus.horizontal_count = '0;
      bus.vertical_count   = '0;
      clear_tallies();
      @(negedge clk_div);
      apply_reset();

      // abbreviated frames: full lines at the interesting vertical positions
      for (int f = 0; f < 3; f++) begin
         for (int li = 0; li < 7; li++) begin
            clear_tallies();
            for (int h = 0; h < H_TOT; h++) step(h, lines[li]);
            chk("line_hsync_low", 32'(t_hs_low), 32'd96);
            chk("line_vsync_low", 32'(t_vs_low), (lines[li] == 490 || lines[li] == 491) ? 32'd800 : 32'd0);
            chk("line_video_on",  32'(t_von),    (lines[li] < 480) ? 32'd640 : 32'd0);
            if (lines[li] == 0)   chk("line_fs", 32'(t_fs), 32'd1);
            if (lines[li] == 480) chk("line_vb", 32'(t_vb), 32'd1);
         end
         chk("frames_counted", 32'(bus.frame_count), 32'(f + 1));
      end

      step(639, 479);
      chk("edge_px", 32'(bus.pixel_x), 32'd639);
      chk("edge_py", 32'(bus.pixel_y), 32'd479);
      chk("edge_von", 32'(bus.video_on), 32'd1);
      step(640, 479);
      chk("edge_von_off", 32'(bus.video_on), 32'd0);
      chk("edge_px_off", 32'(bus.pixel_x), 32'd0);

      // stalled at origin: one strobe, one increment
      step(5, 5);
      fc_before = int'(bus.frame_count);
      clear_tallies();
      for (int i = 0; i < 5; i++) step(0, 0);
      chk("stall_fs_pulses", 32'(t_fs), 32'd1);
      chk("stall_fc_delta", 32'(bus.frame_count), 32'((fc_before + 1) % 65536));
      clear_tallies();
      for (int i = 0; i < 4; i++) step(0, 480);
      chk("stall_vb_pulses", 32'(t_vb), 32'd1);

      // randomized legal counts, biased toward strobe positions and repeats
      for (int i = 0; i < 4000; i++) begin
         int r, h, v;
         r = int'($urandom_range(0, 15));
         if (r < 2)       begin h = 0; v = 0; end
         else if (r == 2) begin h = 0; v = 480; end
         else if (r == 3) begin h = m_prev_h; v = m_prev_v; end
         else begin
            h = int'($urandom_range(0, H_TOT - 1));
            v = int'($urandom_range(0, V_TOT - 1));
         end
         step(h, v);
      end

      // asynchronous reset in the middle of the sync region
      step(700, 490);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(posedge clk_div);
      #1;
      compare_all();
      @(negedge clk_div);
      rst_n = 1'b1;
      step(701, 490);
      chk("post_reset_hsync", 32'(bus.hsync), 32'd0);
      chk("post_reset_vsync", 32'(bus.vsync), 32'd0);

      // sticky error on h out of range, then legal counts
      step(0, 0);
      fc_before = int'(bus.frame_count);
      step(800, 0);
      chk("err_set", 32'(bus.timing_error), 32'd1);
      step(1, 0);
      step(0, 0);
      step(700, 491);
      step(10, 10);
      chk("err_sticky", 32'(bus.timing_error), 32'd1);
      chk("err_fc_frozen", 32'(bus.frame_count), 32'(fc_before));
      chk("err_video_off", 32'(bus.video_on), 32'd0);
      apply_reset();
      step(10, 10);
      chk("err_cleared", 32'(bus.timing_error), 32'd0);

      // vertical and far out-of-range values
      step(0, 525);
      chk("err_v525", 32'(bus.timing_error), 32'd1);
      apply_reset();
      step(65535, 100);
      apply_reset();
      for (int i = 0; i < 200; i++) begin
         step(int'($urandom_range(0, 900)), int'($urandom_range(0, 600)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
